// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encoding and parity helper for the receiver and transmitter.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;
    localparam int DATA_BITS  = 8;

    localparam logic [3:0] CNT_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] CNT_HALF  = 4'(HALF_BIT - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef struct packed {
        logic [7:0] data;
        logic       parity_err;
        logic       frame_err;
    } rx_result_t;

    function automatic logic parity_of(input logic [7:0] data, input logic mode);
        return (^data) ^ mode;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rxs,
    output logic fall
);

    logic meta_q;
    logic rxs_q;
    logic prev_q;

    // Flops reset to the idle-high line level so release never fakes a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx;
            rxs_q  <= meta_q;
            prev_q <= rxs_q;
        end
    end

    assign rxs  = rxs_q;
    assign fall = prev_q & ~rxs_q;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: 8 data bits, one parity bit, one stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic PARITYMODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       dataerror,
    output logic       frameerror,
    output logic       idle
);

    logic       rxs_s;
    logic       fall_s;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       stop_q, stop_d;
    logic       done_q, done_d;
    logic       rdsig_q, rdsig_d;
    logic       idle_q, idle_d;
    rx_result_t result_q, result_d;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rxs  (rxs_s),
        .fall (fall_s)
    );

    // Next-state logic: samples are taken once per bit at cnt_q terminal counts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 4'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        idle_d   = idle_q;
        rdsig_d  = 1'b0;
        result_d = result_q;

        // Publish the frame one cycle after the stop sample.
        if (done_q) begin
            result_d.data       = shift_q;
            result_d.parity_err = (par_q != parity_of(shift_q, PARITYMODE));
            result_d.frame_err  = ~stop_q;
            rdsig_d             = 1'b1;
            idle_d              = 1'b0;
        end else begin
            result_d = result_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                bit_d = 3'd0;
                if (fall_s) begin
                    state_d = ST_START;
                    idle_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = 4'd0;
                    if (rxs_s) begin
                        state_d = ST_IDLE;
                        idle_d  = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {rxs_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    par_d   = rxs_s;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    stop_d  = rxs_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            stop_q   <= 1'b1;
            done_q   <= 1'b0;
            rdsig_q  <= 1'b0;
            idle_q   <= 1'b0;
            result_q <= '{data: 8'h00, parity_err: 1'b0, frame_err: 1'b0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
            rdsig_q  <= rdsig_d;
            idle_q   <= idle_d;
            result_q <= result_d;
        end
    end

    assign dataout    = result_q.data;
    assign dataerror  = result_q.parity_err;
    assign frameerror = result_q.frame_err;
    assign rdsig      = rdsig_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random frames against a frame-level model.
module tb_uart_rx;

    localparam logic PM = 1'b0;
    // Edges from driving the start bit to rdsig high: 2 sync flops + edge detect + 169.
    localparam int unsigned PULSE_LAT = 172;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dataout;
    logic       rdsig;
    logic       dataerror;
    logic       frameerror;
    logic       idle;

    always #5 clk = ~clk;

    uart_rx #(.PARITYMODE(PM)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dataout    (dataout),
        .rdsig      (rdsig),
        .dataerror  (dataerror),
        .frameerror (frameerror),
        .idle       (idle)
    );

    typedef struct {
        int unsigned e;
        logic [7:0]  d;
        logic        de;
        logic        fe;
    } rec_t;

    rec_t        got_q[$];
    rec_t        exp_q[$];
    int unsigned edge_n = 0;
    int          n_cmp  = 0;
    int          n_err  = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (rdsig === 1'b1) got_q.push_back('{edge_n, dataout, dataerror, frameerror});
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            if (i == 5) check("idle_mid_frame", 32'(idle), 32'd1);
            tick(16);
        end
        rx = 1'b1;
    endtask

    // Model: a well-formed start yields one frame whose flags follow directly from the bits sent.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_q.push_back('{edge_n + PULSE_LAT, d, par != ((^d) ^ PM), ~stop});
        drive_frame(d, par, stop);
    endtask

    task automatic check_frames(input string tag);
        rec_t g;
        rec_t x;
        int   waited;
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < 400) begin
            tick(1);
            waited++;
        end
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            g = got_q.pop_front();
            x = exp_q.pop_front();
            check({tag, "_edge"}, g.e, x.e);
            check({tag, "_data"}, 32'(g.d), 32'(x.d));
            check({tag, "_dataerror"}, 32'(g.de), 32'(x.de));
            check({tag, "_frameerror"}, 32'(g.fe), 32'(x.fe));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned e0;
        logic [7:0]  d;
        logic        perr;
        logic        serr;

        rx  = 1'b1;
        rst = 1'b1;
        tick(3);
        check("rst_dataout", 32'(dataout), 32'h00);
        check("rst_rdsig", 32'(rdsig), 32'd0);
        check("rst_dataerror", 32'(dataerror), 32'd0);
        check("rst_frameerror", 32'(frameerror), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        rst = 1'b0;
        tick(4);

        send_frame(8'hA5, 1'b0, 1'b1);
        tick(10);
        check_frames("a5");
        check("a5_idle_after", 32'(idle), 32'd0);

        send_frame(8'h01, 1'b0, 1'b1);
        tick(10);
        check_frames("bad_parity");

        send_frame(8'h3C, 1'b0, 1'b0);
        tick(10);
        check_frames("bad_stop");

        // 5-cycle low glitch: detection edge is e0+3, idle must be low again by e0+12.
        e0 = edge_n;
        rx = 1'b0;
        tick(4);
        check("glitch_idle_high", 32'(idle), 32'd1);
        tick(1);
        rx = 1'b1;
        tick(7);
        check("glitch_edge_ref", edge_n, e0 + 12);
        check("glitch_idle_low", 32'(idle), 32'd0);
        tick(200);
        check_frames("glitch");
        check("glitch_hold_data", 32'(dataout), 32'h3C);
        check("glitch_hold_fe", 32'(frameerror), 32'd1);
        check("glitch_hold_de", 32'(dataerror), 32'd0);

        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        tick(10);
        check_frames("b2b");

        // Line stuck low: one frame of zeros with a bad stop, then nothing until it rises and falls.
        exp_q.push_back('{edge_n + PULSE_LAT, 8'h00, 1'b0, 1'b1});
        rx = 1'b0;
        tick(500);
        rx = 1'b1;
        tick(40);
        check_frames("stuck_low");

        // Reset during D3 of 0x0F aborts the frame; hold reset until the line is idle again.
        rx = 1'b0; tick(16);
        rx = 1'b1; tick(16);
        rx = 1'b1; tick(16);
        rx = 1'b1; tick(16);
        rx = 1'b1; tick(8);
        rst = 1'b1;
        tick(120);
        rst = 1'b0;
        tick(5);
        check_frames("rst_abort");
        check("rst_abort_dataout", 32'(dataout), 32'h00);
        check("rst_abort_idle", 32'(idle), 32'd0);

        send_frame(8'hC3, 1'b0, 1'b1);
        tick(10);
        check_frames("after_rst");

        // Loopback: retransmit what the receiver delivered, as a transmitter fed by dataout would.
        d = dataout;
        exp_q.push_back('{edge_n + PULSE_LAT, 8'hC3, 1'b0, 1'b0});
        drive_frame(d, (^d) ^ PM, 1'b1);
        tick(10);
        check_frames("loopback");

        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom_range(0, 255));
            perr = ($urandom_range(0, 3) == 0);
            serr = ($urandom_range(0, 4) == 0);
            send_frame(d, ((^d) ^ PM) ^ perr, ~serr);
            check_frames("rand");
            if (serr) tick(1 + int'($urandom_range(0, 30)));
            else      tick(int'($urandom_range(0, 30)));
        end

        tick(200);
        check_frames("tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
